mprj_io_serial_loader: RTL

Sequencer that transfers the per-pad user-project I/O configuration words from the housekeeping register file into the pad control blocks' serial shift chain. On a start pulse it walks every pad's configuration register and shifts each word out MSB-first on a divided serial clock. It then issues a load strobe so every pad latches its new configuration at the same time. It sits inside housekeeping, between the Wishbone-visible mprj_ctrl register bank and the chip-level gpio_control_block chain.

---
 rtl/mprj_io_serial_loader_pkg.sv | 12 +
 rtl/mprj_io_serial_loader_tick_gen.sv | 30 +++
 rtl/mprj_io_serial_loader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mprj_io_serial_loader_pkg.sv
// Shared constants for the pad-configuration serial loader.
// The loader's FSM state width and the divider width are also defined here.
package mprj_io_serial_loader_pkg;

    localparam int MPRJ_IO_PADS  = 38;
    localparam int GPIO_CFG_BITS = 13;
    localparam int DEF_CLK_DIV   = 2;

    localparam int STATE_W = 3;
    localparam int DIV_W   = 8;

endpackage

// File: rtl/mprj_io_serial_loader_tick_gen.sv
// Serial-clock phase timer: emits a one-cycle tick every CLK_DIV cycles while enabled.
// While held, the counter stays parked at its reload value, so every phase starts with a full count.
module serial_tick_gen
    import mprj_io_serial_loader_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_hold,
    output logic o_tick
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_hold) begin
            r_cnt <= RELOAD;
        end else if (r_cnt == '0) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    assign o_tick = !i_hold && (r_cnt == '0);

endmodule

// File: rtl/mprj_io_serial_loader.sv
// Walks the per-pad configuration words and shifts them MSB-first into the pad chain,
// last pad first, then pulses a common load strobe.
module mprj_io_serial_loader
    import mprj_io_serial_loader_pkg::*;
#(
    parameter int PADS     = MPRJ_IO_PADS,
    parameter int CFG_BITS = GPIO_CFG_BITS,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(PADS)-1:0]    cfg_idx_o,
    input  logic [CFG_BITS-1:0]        cfg_dat_i,
    output logic                       serial_clock_o,
    output logic                       serial_data_o,
    output logic                       serial_load_o,
    output logic                       serial_resetn_o,
    output logic [STATE_W-1:0]         dbg_state_o
);

    localparam int PW = $clog2(PADS);
    localparam int BW = $clog2(CFG_BITS);

    localparam logic [STATE_W-1:0] S_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH    = 3'd1;
    localparam logic [STATE_W-1:0] S_SHIFT_LO = 3'd2;
    localparam logic [STATE_W-1:0] S_SHIFT_HI = 3'd3;
    localparam logic [STATE_W-1:0] S_LOAD     = 3'd4;
    localparam logic [STATE_W-1:0] S_DONE     = 3'd5;

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_next;
    logic [PW-1:0]       r_pad;
    logic [BW-1:0]       r_bit;
    logic [CFG_BITS-1:0] r_sr;
    logic                r_fresh;
    logic                r_sdo;
    logic                r_resetn;
    logic                w_sdo;
    logic                w_tick;
    logic                w_hold;

    assign w_hold = wb_rst_i || (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_DONE);

    serial_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_hold (w_hold),
        .o_tick (w_tick)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_pad    <= '0;
            r_bit    <= '0;
            r_sr     <= '0;
            r_fresh  <= 1'b0;
            r_sdo    <= 1'b0;
            r_resetn <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_resetn <= 1'b1;
            r_sdo    <= w_sdo;
            // Read data arrives the cycle after FETCH; latch it at the end of that cycle.
            r_fresh  <= (r_state == S_FETCH);
            if (r_fresh) begin
                r_sr <= cfg_dat_i;
            end
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_pad <= PW'(PADS - 1);
                        r_bit <= BW'(CFG_BITS - 1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_tick) begin
                        if (r_bit != '0) begin
                            r_bit <= r_bit - BW'(1);
                        end else if (r_pad != '0) begin
                            r_pad <= r_pad - PW'(1);
                            r_bit <= BW'(CFG_BITS - 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_next = S_FETCH;
            S_FETCH:    w_next = S_SHIFT_LO;
            S_SHIFT_LO: if (w_tick) w_next = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (w_tick) begin
                    if (r_bit != '0)      w_next = S_SHIFT_LO;
                    else if (r_pad != '0) w_next = S_FETCH;
                    else                  w_next = S_LOAD;
                end
            end
            S_LOAD:     if (w_tick) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Data may only move at the start of SHIFT_LO; everywhere else it is held or forced low.
    always_comb begin
        busy_o         = (r_state != S_IDLE);
        done_o         = (r_state == S_DONE);
        serial_clock_o = (r_state == S_SHIFT_HI);
        serial_load_o  = (r_state == S_LOAD);
        w_sdo          = r_sdo;
        case (r_state)
            S_SHIFT_LO:             w_sdo = r_fresh ? cfg_dat_i[r_bit] : r_sr[r_bit];
            S_IDLE, S_LOAD, S_DONE: w_sdo = 1'b0;
            default: ;
        endcase
        serial_data_o = w_sdo;
    end

    assign cfg_idx_o       = r_pad;
    assign serial_resetn_o = r_resetn;
    assign dbg_state_o     = r_state;

endmodule
